pack_number: RTL and testbench



---
 rtl/pack_number.sv | 146 ++++++++++++++
 tb/tb_pack_number.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pack_number.sv
// Packs sign, signed biased exponent and an unnormalized extended mantissa into an
// IEEE-754 single: one-bit-per-cycle normalization, round-to-nearest-even, saturate/flush.
`timescale 1ns/1ps
module pack_number #(
    parameter int EXP_W  = 10,
    parameter int MANT_W = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [MANT_W-1:0] mantis_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       number,
    output logic              overflow,
    output logic              underflow,
    output logic              inexact
);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    localparam logic signed [EXP_W-1:0] EXP_INF  = EXP_W'(255);
    localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;
    localparam logic signed [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

    state_t                   state_q, state_d;
    logic                     sign_q, sign_d;
    logic signed [EXP_W-1:0]  exp_q, exp_d;
    logic [MANT_W-1:0]        mant_q, mant_d;
    logic [31:0]              number_q, number_d;
    logic                     ovf_q, ovf_d;
    logic                     unf_q, unf_d;
    logic                     inx_q, inx_d;

    // Rounding datapath, only consumed in ROUND.
    logic                     guard, rs, lsb, inc;
    logic [24:0]              rounded;
    logic signed [EXP_W-1:0]  exp_r;
    logic [22:0]              frac_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            number_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            number_q <= number_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inx_q    <= inx_d;
        end
    end

    always_comb begin
        guard   = mant_q[MANT_W-26];
        rs      = |mant_q[MANT_W-27:0];
        lsb     = mant_q[MANT_W-25];
        inc     = guard & (rs | lsb);
        rounded = {1'b0, mant_q[MANT_W-2:MANT_W-25]} + 25'(inc);
        exp_r   = rounded[24] ? exp_q + EXP_ONE : exp_q;
        frac_r  = rounded[24] ? rounded[23:1] : rounded[22:0];
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        number_d = number_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inx_d    = inx_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = sign_in;
                    exp_d   = exp_in;
                    mant_d  = mantis_in;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (mant_q == '0) begin
                    number_d = {sign_q, 31'b0};
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    inx_d    = 1'b0;
                    state_d  = DONE;
                end else if (mant_q[MANT_W-1]) begin
                    // Shifted-out bit folds into sticky so rounding still sees it.
                    mant_d  = {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
                    exp_d   = exp_q + EXP_ONE;
                    state_d = ROUND;
                end else if (mant_q[MANT_W-2]) begin
                    state_d = ROUND;
                end else begin
                    mant_d = mant_q << 1;
                    exp_d  = exp_q - EXP_ONE;
                end
            end
            ROUND: begin
                if (exp_r >= EXP_INF) begin
                    number_d = {sign_q, 8'hFF, 23'b0};
                    ovf_d    = 1'b1;
                    unf_d    = 1'b0;
                    inx_d    = 1'b1;
                end else if (exp_r <= EXP_ZERO) begin
                    number_d = {sign_q, 31'b0};
                    ovf_d    = 1'b0;
                    unf_d    = 1'b1;
                    inx_d    = 1'b1;
                end else begin
                    number_d = {sign_q, exp_r[7:0], frac_r};
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    inx_d    = guard | rs;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign number    = number_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign inexact   = inx_q;

endmodule

// File: tb/tb_pack_number.sv
// Directed bench for pack_number: value-level float model plus hand-computed literals.
`timescale 1ns/1ps
module tb_pack_number;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sign_in = 1'b0;
    logic [9:0]  exp_in = '0;
    logic [27:0] mantis_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] number;
    logic        overflow, underflow, inexact;

    pack_number #(.EXP_W(10), .MANT_W(28)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign_in(sign_in), .exp_in(exp_in), .mantis_in(mantis_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .number(number), .overflow(overflow), .underflow(underflow), .inexact(inexact)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_num = '0;
    logic [2:0]  m_fl = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Value model: value = m * 2^(e-127-26); normalize to 24 significant bits,
    // round the 3 trailing bits against the half point, then pack.
    function automatic void model(input logic s, input int e, input logic [27:0] m,
                                  output logic [31:0] num, output logic [2:0] fl,
                                  output int lat);
        longint v, keep, rem;
        int     ee, p;
        logic   up;
        num = {s, 31'b0};
        fl  = 3'b000;
        lat = 2;
        if (m != 0) begin
            v  = longint'(m);
            ee = e;
            lat = 3;
            p = 27;
            while (m[p] == 1'b0) p--;
            if (p == 27) begin
                v  = (v >> 1) | (v & 1);
                ee = ee + 1;
            end else if (p < 26) begin
                v   = v << (26 - p);
                ee  = ee - (26 - p);
                lat = lat + (26 - p);
            end
            keep = v >> 3;
            rem  = v & 7;
            up   = (rem > 4) || (rem == 4 && keep[0]);
            keep = keep + (up ? 1 : 0);
            if (keep >= (64'sd1 << 24)) begin
                keep = keep >> 1;
                ee   = ee + 1;
            end
            if (ee >= 255) begin
                num = {s, 8'hFF, 23'b0};
                fl  = 3'b101;
            end else if (ee <= 0) begin
                num = {s, 31'b0};
                fl  = 3'b011;
            end else begin
                num = {s, ee[7:0], keep[22:0]};
                fl  = {2'b00, rem != 0};
            end
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            check("out_valid_expected", {31'b0, m_valid}, 32'd1);
            check("model_number", number, m_num);
            check("model_flags", {29'b0, overflow, underflow, inexact}, {29'b0, m_fl});
            check("in_ready_in_done", {31'b0, in_ready}, 32'd0);
        end
    end

    task automatic run_op(input logic s, input int e, input logic [27:0] m, input int hold,
                          input logic [31:0] lnum, input logic [2:0] lfl);
        logic [31:0] mn;
        logic [2:0]  mf;
        int          ml, n;
        model(s, e, m, mn, mf, ml);
        @(negedge clk);
        check("in_ready_idle", {31'b0, in_ready}, 32'd1);
        sign_in   = s;
        exp_in    = e[9:0];
        mantis_in = m;
        in_valid  = 1'b1;
        m_num     = mn;
        m_fl      = mf;
        m_valid   = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(ml));
        check("lit_number", number, lnum);
        check("lit_flags", {29'b0, overflow, underflow, inexact}, {29'b0, lfl});
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        m_valid = 1'b0;
        check("valid_drop", {31'b0, out_valid}, 32'd0);
        check("in_ready_back", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_number", number, 32'h0);
        check("rst_flags", {29'b0, overflow, underflow, inexact}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(1'b0, 127, 28'h4000000, 10, 32'h3F800000, 3'b000);
        run_op(1'b0, 127, 28'h8000000, 0, 32'h40000000, 3'b000);
        run_op(1'b0, 130, 28'h0000008, 2, 32'h35800000, 3'b000);
        run_op(1'b0, 127, 28'h4000004, 0, 32'h3F800000, 3'b001);
        run_op(1'b0, 127, 28'h400000C, 1, 32'h3F800002, 3'b001);
        run_op(1'b0, 127, 28'h4000006, 0, 32'h3F800001, 3'b001);
        run_op(1'b0, 254, 28'h7FFFFFC, 0, 32'h7F800000, 3'b101);
        run_op(1'b0, 254, 28'h4000000, 0, 32'h7F000000, 3'b000);
        run_op(1'b0, 0,   28'h4000000, 0, 32'h00000000, 3'b011);
        run_op(1'b1, 0,   28'h4000000, 0, 32'h80000000, 3'b011);
        run_op(1'b0, 0,   28'h8000000, 0, 32'h00800000, 3'b000);
        run_op(1'b1, 127, 28'h0000000, 0, 32'h80000000, 3'b000);
        run_op(1'b1, 200, 28'h8000001, 0, 32'hE4800000, 3'b001);
        run_op(1'b0, 300, 28'h4000000, 0, 32'h7F800000, 3'b101);
        run_op(1'b0, -5,  28'h4000000, 0, 32'h00000000, 3'b011);
        run_op(1'b0, 1,   28'h0000001, 0, 32'h00000000, 3'b011);

        // Abort a long normalization with an asynchronous reset.
        @(negedge clk);
        sign_in   = 1'b0;
        exp_in    = 10'd150;
        mantis_in = 28'h0000001;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        check("abort_number", number, 32'h0);
        check("abort_flags", {29'b0, overflow, underflow, inexact}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_emit", {31'b0, out_valid}, 32'd0);
        check("abort_idle", {31'b0, in_ready}, 32'd1);

        run_op(1'b1, 128, 28'h6000000, 3, 32'hC0400000, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
